// File: rtl/instr_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_pkg
// Shared definitions for the UART program loader:
//   state_t            - loader FSM state encodings (IDLE, RECV, WRITE, DONE)
//   NBITS_DEFAULT      - default instruction word width
//   HALT_WORD_DEFAULT  - default end-of-program marker
//   BYTES_PER_WORD     - bytes per instruction word for the default width
//   bytes_per_word()   - the same figure for any word width
// -----------------------------------------------------------------------------
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          NBITS_DEFAULT     = 32;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD    = NBITS_DEFAULT / 8;

    function automatic int bytes_per_word(input int nbits);
        return nbits / 8;
    endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
// Write port into the instruction memory shared with instructionFetch.
//   mem_wr_en    - one-cycle write strobe
//   mem_addr     - word address of the write
//   mem_wr_data  - instruction word to write
// Modports: master (the loader drives the bus), slave (the memory samples it).
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
    parameter int NBITS     = 32,
    parameter int ADDR_BITS = 8
);
    logic                 mem_wr_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [NBITS-1:0]     mem_wr_data;

    modport master (output mem_wr_en, output mem_addr, output mem_wr_data);
    modport slave  (input  mem_wr_en, input  mem_addr, input  mem_wr_data);
endinterface

// File: rtl/instr_mem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs received bytes MSB-first into an instruction word.
//   i_clk, i_reset  - clock, synchronous active-high reset
//   i_clear         - restart assembly at byte 0 (new program load)
//   i_shift_en      - accept i_byte this cycle
//   i_byte          - received byte
//   o_word          - assembled word (first byte ends up in the top byte)
//   o_word_ready    - the byte accepted this cycle completes a word
// -----------------------------------------------------------------------------
module word_assembler
    import instr_mem_loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_shift_en,
    input  logic [7:0]       i_byte,
    output logic [NBITS-1:0] o_word,
    output logic             o_word_ready
);

    localparam int                 BPW       = bytes_per_word(NBITS);
    localparam int                 CNT_BITS  = $clog2(BPW);
    localparam logic [CNT_BITS-1:0] LAST_BYTE = CNT_BITS'(BPW - 1);

    logic [CNT_BITS-1:0] byte_cnt;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            // NOTE: this is a small shift register, so it is reset; the
            // instruction memory it feeds lives outside and is never cleared.
            o_word   <= '0;
            byte_cnt <= '0;
        end else if (i_shift_en) begin
            o_word   <= {o_word[NBITS-9:0], i_byte};
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
        end
    end

    // Internal to the loader only: it steers the FSM, never a block output.
    assign o_word_ready = i_shift_en && (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
// Loads a program received byte-by-byte from the UART into instruction memory,
// holding the CPU while the load runs.
//   i_clk, i_reset   - clock, synchronous active-high reset
//   i_start          - one-cycle pulse starting a load (ignored while loading)
//   i_rx_data/valid  - received byte stream, one byte per valid cycle
//   mem              - instruction memory write port (master)
//   o_cpu_hold       - high in RECV and WRITE; stalls and resets fetch
//   o_done           - load finished, held until the next load or reset
//   o_full           - load ended on the last address rather than HALT_WORD
//   o_word_count     - words written in the current or last load
// -----------------------------------------------------------------------------
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               ADDR_BITS = 8,
    parameter logic [NBITS-1:0] HALT_WORD = NBITS'(HALT_WORD_DEFAULT)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    instr_mem_loader_if.master   mem,
    output logic                 o_cpu_hold,
    output logic                 o_done,
    output logic                 o_full,
    output logic [ADDR_BITS:0]   o_word_count
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS:0]   word_count_q;
    logic                 full_q;

    logic [NBITS-1:0]     word;
    logic                 word_ready;
    logic                 load_start;
    logic                 shift_en;
    logic                 is_halt;
    logic                 at_last;
    logic                 write_ends_load;

    assign is_halt         = (word == HALT_WORD);
    assign at_last         = (addr_q == LAST_ADDR);
    assign write_ends_load = is_halt || at_last;
    assign load_start      = i_start && (state_q == IDLE || state_q == DONE);

    // A byte arriving during WRITE already belongs to the next word, unless
    // this write closes the load, in which case it is dropped.
    assign shift_en = i_rx_valid &&
                      ((state_q == RECV) || (state_q == WRITE && !write_ends_load));

    word_assembler #(.NBITS(NBITS)) u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (load_start),
        .i_shift_en   (shift_en),
        .i_byte       (i_rx_data),
        .o_word       (word),
        .o_word_ready (word_ready)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start)    state_d = RECV;
            RECV:    if (word_ready) state_d = WRITE;
            WRITE:   state_d = write_ends_load ? DONE : RECV;
            DONE:    if (i_start)    state_d = RECV;
            default: state_d = IDLE;
        endcase
    end

    // Load datapath: address, word count and end-of-load cause. The count
    // advances on the edge that closes the WRITE cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || load_start) begin
            addr_q       <= '0;
            word_count_q <= '0;
            full_q       <= 1'b0;
        end else if (state_q == WRITE) begin
            word_count_q <= word_count_q + 1'b1;
            if (!is_halt && at_last) full_q <= 1'b1;
            if (!write_ends_load)    addr_q <= addr_q + 1'b1;
        end
    end

    // Outputs: decoded from the state register or taken straight from registers.
    always_comb begin
        mem.mem_wr_en   = (state_q == WRITE);
        mem.mem_addr    = addr_q;
        mem.mem_wr_data = word;
        o_cpu_hold      = (state_q == RECV) || (state_q == WRITE);
        o_done          = (state_q == DONE);
        o_full          = full_q;
        o_word_count    = word_count_q;
    end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter NBITS, default 32, instruction word width in bits.
REQ-002 Parameter ADDR_BITS, default 8, word-address width; memory depth = 2**ADDR_BITS words.
REQ-003 Parameter HALT_WORD, default 32'hFFFF_FFFF, end-of-program marker.
REQ-004 i_clk  input  1  single clock; all state changes on posedge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  one-cycle pulse; begins a program load.
REQ-007 i_rx_data  input  8  received byte from the UART receiver.
REQ-008 i_rx_valid  input  1  i_rx_data valid this cycle; one byte per asserted cycle.
REQ-009 o_mem_wr_en  output  1  instruction memory write strobe.
REQ-010 o_mem_addr  output  ADDR_BITS  word address of the write.
REQ-011 o_mem_wr_data  output  NBITS  instruction word to write.
REQ-012 o_cpu_hold  output  1  high while loading; drives fetch PCWrite low and holds fetch in reset.
REQ-013 o_done  output  1  load finished; held until next i_start or reset.
REQ-014 o_full  output  1  load ended by filling the last address, not by HALT_WORD.
REQ-015 o_word_count  output  ADDR_BITS+1  number of words written in the current or last load.

Function
REQ-016 FSM SHALL have exactly four states: IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: i_start -> RECV; write address, byte counter and o_word_count cleared to 0.
REQ-018 RECV: each i_rx_valid shifts i_rx_data into the word assembler MSB-first (first byte -> bits [31:24]).
REQ-019 RECV: on acceptance of the 4th byte -> WRITE next cycle; byte counter returns to 0.
REQ-020 WRITE lasts exactly one cycle: o_mem_wr_en=1, o_mem_addr = current address, o_mem_wr_data = assembled word; o_word_count increments by 1 that cycle.
REQ-021 Write latency: o_mem_wr_en asserted on the cycle immediately after the 4th byte's valid cycle.
REQ-022 WRITE exit: word == HALT_WORD -> DONE (o_full=0); else address == 2**ADDR_BITS-1 -> DONE (o_full=1); else address+1 -> RECV.
REQ-023 HALT_WORD SHALL itself be written to memory.
REQ-024 i_rx_valid during WRITE when exiting to RECV: byte accepted as byte 0 of the next word; when exiting to DONE: byte discarded.
REQ-025 i_rx_valid in IDLE or DONE SHALL be ignored; i_start in RECV or WRITE SHALL be ignored.
REQ-026 DONE: o_done=1; i_start -> RECV with same clearing as REQ-017, o_done and o_full cleared.
REQ-027 o_cpu_hold = 1 in RECV and WRITE, 0 in IDLE and DONE.
REQ-028 Address never wraps; no write beyond 2**ADDR_BITS-1.
REQ-029 All outputs SHALL be registered or decoded from the state register only; no combinational path from inputs to outputs.

Reset
REQ-030 i_reset high at a posedge -> IDLE; address, byte counter, assembler, o_word_count = 0; o_mem_wr_en, o_cpu_hold, o_done, o_full = 0.
REQ-031 Reset mid-load (RECV or WRITE) SHALL abort with no further write; a write strobe coinciding with the reset edge's cycle is not issued.
REQ-032 Reset has priority over i_start and i_rx_valid in the same cycle.

Structure
REQ-033 Shared package holds FSM state encodings, default HALT_WORD, and BYTES_PER_WORD = NBITS/8.
REQ-034 One sub-module, word_assembler: byte shift register plus 2-bit byte counter, with clear and "word ready" output.
REQ-035 Top instantiates word_assembler and the FSM; memory stays outside this block, shared with instructionFetch.

Verification
REQ-036 Reset, i_start, bytes 20 08 00 05, FF FF FF FF -> writes addr0=0x20080005, addr1=0xFFFFFFFF; o_done=1, o_full=0, o_word_count=2.
REQ-037 Bytes spaced by 3 idle cycles vs back-to-back -> identical writes; o_mem_wr_en exactly 1 cycle after each 4th byte.
REQ-038 ADDR_BITS=2, 4 non-halt words -> writes addr0..3, o_done=1, o_full=1, 5th word's bytes ignored, no write at addr 0.
REQ-039 Reset asserted after 2 bytes of word 1 -> no write, o_cpu_hold=0 next cycle; fresh i_start reloads from addr0.
REQ-040 Byte valid in WRITE cycle of word 0 (non-halt) -> becomes bits [31:24] of word 1; i_start during RECV -> no effect on address.
